// File: rtl/aes_round_scheduler_if.sv
// rtl/aes_round_scheduler_if.sv - block in/out handshake bundle for the AES round scheduler
//
// Purpose: carries the upstream (plaintext/key) and downstream (ciphertext)
// valid/ready handshakes between the scheduler and its neighbours.
// Signals:
//   in_valid   upstream block and key are valid
//   in_ready   scheduler accepts a block this cycle
//   out_valid  datapath holds a finished ciphertext
//   out_ready  downstream accepts the ciphertext
// Modports: master = upstream/downstream side, slave = scheduler side.
interface aes_round_scheduler_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - round sequencing FSM for an iterative AES datapath
//
// Purpose: accepts one block at a time, steps the datapath through
// NUM_ROUNDS rounds (MixColumns skipped on the last), then holds the
// ciphertext until downstream takes it. A new block may be accepted in the
// same cycle the previous ciphertext leaves, giving NUM_ROUNDS+1 cycles per block.
// Ports:
//   CLK, nRST    clock, asynchronous active-low reset
//   abort        synchronous cancel of the block in flight (highest priority)
//   bus          in/out valid/ready handshakes (slave modport)
//   Round_Num    registered round index presented to the datapath
//   load_state   capture plaintext^key and the initial key
//   round_en     datapath state register update
//   key_en       advance key expansion by one round key
//   mix_en       MixColumns enable (0 on the final round)
//   busy         FSM not idle
//   Done         one-cycle pulse on each output handshake
module aes_round_scheduler #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  abort,
  aes_round_scheduler_if.slave  bus,
  output logic [3:0]            Round_Num,
  output logic                  load_state,
  output logic                  round_en,
  output logic                  key_en,
  output logic                  mix_en,
  output logic                  busy,
  output logic                  Done
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    load_state    = 1'b0;
    round_en      = 1'b0;
    key_en        = 1'b0;
    mix_en        = 1'b0;
    Done          = 1'b0;

    if (round_q > LAST) begin
      // corrupted round counter: drop whatever was in flight
      state_d = IDLE;
      round_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // nRST gating keeps in_ready low while reset is held
          bus.in_ready = nRST && !abort;
          load_state   = bus.in_valid && bus.in_ready;
          round_d      = 4'd0;
          if (load_state) begin
            state_d = ROUND;
            round_d = 4'd1;
          end
        end

        ROUND: begin
          mix_en = (round_q != LAST);
          if (abort || round_q == 4'd0) begin
            state_d = IDLE;
            round_d = 4'd0;
          end else begin
            round_en = 1'b1;
            key_en   = 1'b1;
            if (round_q == LAST) begin
              state_d = HOLD;
            end else begin
              round_d = round_q + 4'd1;
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state_d = IDLE;
            round_d = 4'd0;
          end else begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
            Done          = bus.out_ready;
            // accepting the next block only alongside the output handshake
            // lets back-to-back blocks run without an idle bubble
            load_state    = bus.in_valid && bus.in_ready;
            if (Done) begin
              state_d = load_state ? ROUND : IDLE;
              round_d = load_state ? 4'd1 : 4'd0;
            end
          end
        end

        default: begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign Round_Num = round_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb/tb_aes_round_scheduler.sv - directed scoreboard bench for aes_round_scheduler
module tb_aes_round_scheduler;

  logic CLK;
  logic nRST;
  logic ab_a, ab_b;
  logic [3:0] rn_a, rn_b;
  logic ld_a, re_a, ke_a, me_a, busy_a, done_a;
  logic ld_b, re_b, ke_b, me_b, busy_b, done_b;

  aes_round_scheduler_if a_if ();
  aes_round_scheduler_if b_if ();

  aes_round_scheduler #(.NUM_ROUNDS(10)) dut_a (
    .CLK(CLK), .nRST(nRST), .abort(ab_a), .bus(a_if),
    .Round_Num(rn_a), .load_state(ld_a), .round_en(re_a), .key_en(ke_a),
    .mix_en(me_a), .busy(busy_a), .Done(done_a)
  );

  aes_round_scheduler #(.NUM_ROUNDS(14)) dut_b (
    .CLK(CLK), .nRST(nRST), .abort(ab_b), .bus(b_if),
    .Round_Num(rn_b), .load_state(ld_b), .round_en(re_b), .key_en(ke_b),
    .mix_en(me_b), .busy(busy_b), .Done(done_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_a[$];
  int q_b[$];
  logic ova_prev = 1'b0;
  logic ovb_prev = 1'b0;
  int drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start of a cycle: inputs may be driven after this returns
  task automatic next();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  // sample point; scoreboard pops on each rising out_valid
  task automatic look();
    #2;
    if (a_if.out_valid === 1'b1 && ova_prev !== 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_ov", a_if.out_valid, 0);
      else chk("a_latency", cyc, q_a.pop_front());
    end
    if (b_if.out_valid === 1'b1 && ovb_prev !== 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_ov", b_if.out_valid, 0);
      else chk("b_latency", cyc, q_b.pop_front());
    end
    ova_prev = a_if.out_valid;
    ovb_prev = b_if.out_valid;
  endtask

  task automatic tick();
    next();
    look();
  endtask

  // called in the first ROUND cycle; ends in the first HOLD cycle
  task automatic run_rounds(input bit use_b);
    int nr;
    nr = use_b ? 14 : 10;
    for (int r = 1; r <= nr; r++) begin
      chk(use_b ? "b_rn" : "a_rn", use_b ? rn_b : rn_a, r);
      chk(use_b ? "b_mix" : "a_mix", use_b ? me_b : me_a, (r != nr) ? 1 : 0);
      chk(use_b ? "b_round_en" : "a_round_en", use_b ? (re_b & ke_b) : (re_a & ke_a), 1);
      chk(use_b ? "b_ir_round" : "a_ir_round", use_b ? b_if.in_ready : a_if.in_ready, 0);
      chk(use_b ? "b_ov_round" : "a_ov_round", use_b ? b_if.out_valid : a_if.out_valid, 0);
      tick();
    end
    chk(use_b ? "b_hold_ov" : "a_hold_ov", use_b ? b_if.out_valid : a_if.out_valid, 1);
    chk(use_b ? "b_hold_rn" : "a_hold_rn", use_b ? rn_b : rn_a, nr);
    chk(use_b ? "b_hold_en" : "a_hold_en", use_b ? (re_b | ke_b) : (re_a | ke_a), 0);
  endtask

  // start a block on dut_a from IDLE; ends in its first ROUND cycle
  task automatic start_a();
    next();
    a_if.in_valid = 1'b1;
    look();
    chk("a_load", ld_a, 1);
    q_a.push_back(cyc + 11);
    next();
    a_if.in_valid = 1'b0;
    look();
  endtask

  task automatic drain_a();
    next();
    a_if.out_ready = 1'b1;
    look();
    chk("a_done", done_a, 1);
    next();
    a_if.out_ready = 1'b0;
    look();
    chk("a_done_pulse", done_a, 0);
    chk("a_idle_busy", busy_a, 0);
    chk("a_idle_rn", rn_a, 0);
  endtask

  initial begin
    nRST = 1'b0;
    ab_a = 1'b0; ab_b = 1'b0;
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;

    // reset state
    tick();
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_ov", a_if.out_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rn", rn_a, 0);
    chk("rst_load", ld_a, 0);
    next();
    nRST = 1'b1;
    look();
    chk("rel_in_ready", a_if.in_ready, 1);

    // single block then backpressure
    start_a();
    run_rounds(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ov", a_if.out_valid, 1);
      chk("bp_rn", rn_a, 10);
      chk("bp_done", done_a, 0);
    end
    drain_a();
    chk("bp_ir_idle", a_if.in_ready, 1);

    // back-to-back blocks
    start_a();
    run_rounds(1'b0);
    next();
    a_if.in_valid = 1'b1;
    a_if.out_ready = 1'b1;
    look();
    chk("b2b_done", done_a, 1);
    chk("b2b_load", ld_a, 1);
    q_a.push_back(cyc + 11);
    next();
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b0;
    look();
    chk("b2b_busy", busy_a, 1);
    run_rounds(1'b0);
    drain_a();

    // abort at round 5
    start_a();
    for (int r = 1; r <= 4; r++) begin
      chk("ab_rn", rn_a, r);
      tick();
    end
    ab_a = 1'b1;
    #1;
    chk("ab_rn5", rn_a, 5);
    chk("ab_en", re_a | ke_a | ld_a, 0);
    chk("ab_ir", a_if.in_ready, 0);
    drop = q_a.pop_back();
    next();
    ab_a = 1'b0;
    look();
    chk("ab_idle_rn", rn_a, 0);
    chk("ab_idle_busy", busy_a, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("ab_no_ov", a_if.out_valid, 0);
    end
    start_a();
    run_rounds(1'b0);
    drain_a();

    // abort in IDLE only blocks acceptance
    next();
    ab_a = 1'b1;
    a_if.in_valid = 1'b1;
    look();
    chk("idle_ab_ir", a_if.in_ready, 0);
    chk("idle_ab_load", ld_a, 0);
    next();
    ab_a = 1'b0;
    a_if.in_valid = 1'b0;
    look();
    chk("idle_ab_busy", busy_a, 0);

    // asynchronous reset at round 7
    start_a();
    for (int r = 1; r <= 6; r++) tick();
    chk("rst7_rn", rn_a, 7);
    nRST = 1'b0;
    #1;
    chk("rst7_rn0", rn_a, 0);
    chk("rst7_busy", busy_a, 0);
    chk("rst7_en", re_a | ke_a | ld_a | done_a, 0);
    chk("rst7_ir", a_if.in_ready, 0);
    chk("rst7_ov", a_if.out_valid, 0);
    drop = q_a.pop_back();
    tick();
    nRST = 1'b1;
    #1;
    chk("rst7_rel_ir", a_if.in_ready, 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("rst7_no_ov", a_if.out_valid, 0);
    end

    // fourteen-round instance
    next();
    b_if.in_valid = 1'b1;
    look();
    chk("b_load", ld_b, 1);
    q_b.push_back(cyc + 15);
    next();
    b_if.in_valid = 1'b0;
    look();
    run_rounds(1'b1);
    next();
    b_if.out_ready = 1'b1;
    look();
    chk("b_done", done_b, 1);
    next();
    b_if.out_ready = 1'b0;
    look();
    chk("b_idle_busy", busy_b, 0);

    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, is the number of cipher rounds; legal values are 10, 12 and 14.
REQ-002 CLK  input  1  is the system clock; all state updates SHALL occur on the rising edge.
REQ-003 nRST  input  1  is the reset, which SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  SHALL indicate that the upstream plaintext and key are valid.
REQ-005 in_ready  output  1  SHALL indicate that the scheduler accepts a new block this cycle.
REQ-006 out_valid  output  1  SHALL indicate that the datapath holds a finished ciphertext.
REQ-007 out_ready  input  1  SHALL indicate that downstream accepts the ciphertext.
REQ-008 abort  input  1  is a synchronous cancel of the current block.
REQ-009 Round_Num  output  4  SHALL carry the current round index presented to the datapath.
REQ-010 load_state  output  1  SHALL command the datapath to capture plaintext XOR key (round 0) and load the initial key.
REQ-011 round_en  output  1  SHALL command the datapath state register to update with the round result.
REQ-012 key_en  output  1  SHALL command the key expansion to advance one round key.
REQ-013 mix_en  output  1  SHALL enable MixColumns; it is 0 on the final round.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-015 Done  output  1  SHALL pulse for one cycle on each output handshake.

Function
REQ-016 The FSM SHALL have the states IDLE, ROUND and HOLD, with Round_Num and the state registered.
REQ-017 In IDLE, the following SHALL hold:
- in_ready = !abort;
- Round_Num = 0;
- on in_valid && in_ready, load_state = 1 that cycle and the next state is ROUND with Round_Num = 1.
REQ-018 In ROUND, the following SHALL hold:
- round_en = 1 and key_en = 1 every cycle;
- mix_en = (Round_Num != NUM_ROUNDS);
- Round_Num increments by 1 per edge;
- when Round_Num == NUM_ROUNDS, the next state is HOLD and Round_Num holds at NUM_ROUNDS.
REQ-019 In HOLD, the following SHALL hold:
- out_valid = 1 and round_en = key_en = 0;
- out_valid SHALL stay high, with Round_Num stable, until out_ready.
REQ-020 The output handshake is out_valid && out_ready; it SHALL produce Done = 1 combinationally in the same cycle.
REQ-021 In HOLD, in_ready = out_ready && !abort, allowing back-to-back blocks.
REQ-022 If, in HOLD, both handshakes occur in the same cycle:
- load_state = 1 and Done = 1 in that cycle;
- the next state is ROUND with Round_Num = 1, with no idle bubble.
REQ-023 If, in HOLD, only the output handshake occurs, the next state is IDLE with Round_Num = 0.
REQ-024 Latency from input handshake at edge E to out_valid high SHALL be NUM_ROUNDS edges, so out_valid is first seen in the cycle after edge E+NUM_ROUNDS.
REQ-025 Throughput SHALL be one block per NUM_ROUNDS+1 cycles under continuous valid/ready.
REQ-026 in_ready SHALL be 0 in ROUND; in_valid there is ignored and the block is not captured.
REQ-027 abort SHALL have the highest priority; when abort = 1 in ROUND or HOLD:
- next state is IDLE and Round_Num = 0;
- out_valid, Done, load_state, round_en and key_en are 0 that cycle.
REQ-028 abort = 1 in IDLE SHALL have no effect other than forcing in_ready = 0.
REQ-029 An illegal state encoding, or Round_Num > NUM_ROUNDS, SHALL return to IDLE with Round_Num = 0 on the next edge.
REQ-030 All command outputs SHALL be decoded from the state and the inputs, with no extra register stage.

Reset
REQ-031 nRST low SHALL immediately force state = IDLE, Round_Num = 0, and out_valid = round_en = key_en = load_state = Done = busy = 0.
REQ-032 While nRST is low, in_ready = 0; after release, in_ready = 1 in the first cycle.
REQ-033 An assertion of nRST mid-block SHALL discard the block, and no out_valid SHALL follow.

Verification
REQ-034 Single block, NUM_ROUNDS=10, the bench SHALL check:
- in_valid pulse in IDLE -> load_state = 1 in the handshake cycle;
- Round_Num 1..10 on successive cycles, with mix_en = 0 only at Round_Num = 10;
- out_valid high the cycle after Round_Num 10 ends.
REQ-035 Backpressure: out_ready low for 5 cycles in HOLD -> out_valid and Round_Num = 10 held stable; out_ready high -> Done = 1 for one cycle, then IDLE.
REQ-036 Back-to-back: in_valid and out_ready both high in HOLD -> Done = 1 and load_state = 1 in the same cycle; Round_Num = 1 the next cycle.
REQ-037 Abort at Round_Num = 5 -> IDLE and Round_Num = 0 next cycle; no out_valid; next in_valid is accepted normally.
REQ-038 nRST pulse at Round_Num = 7 -> all outputs reset asynchronously; in_ready = 1 after release.
REQ-039 NUM_ROUNDS=14 -> Round_Num counts 1..14 and mix_en = 0 only at 14.
